// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage,
// with the inter-group carry passed through registers and a global valid/ready advance.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSTAGE = WIDTH / BLOCK;

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;

  logic [WIDTH-1:0] r_a   [NSTAGE];
  logic [WIDTH-1:0] r_b   [NSTAGE];
  logic [WIDTH-1:0] r_s   [NSTAGE];
  logic             r_c   [NSTAGE];
  logic             r_ovf [NSTAGE];
  logic             r_v   [NSTAGE];

  // A single enable for every stage: the pipe only stalls when a result is stuck at the output.
  assign w_adv    = !r_v[NSTAGE-1] || out_ready;
  assign in_ready = w_adv;
  assign w_bx     = sub ? ~b : b;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [WIDTH-1:0] w_ain;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_sbase;
    logic [WIDTH-1:0] w_snext;
    logic             w_gc;
    logic             w_vin;
    logic [BLOCK-1:0] w_g;
    logic [BLOCK-1:0] w_p;
    logic [BLOCK:0]   w_c;

    if (k == 0) begin : g_first
      assign w_ain   = a;
      assign w_bin   = w_bx;
      assign w_sbase = '0;
      assign w_gc    = sub | cin;
      assign w_vin   = in_valid;
    end else begin : g_rest
      assign w_ain   = r_a[k-1];
      assign w_bin   = r_b[k-1];
      assign w_sbase = r_s[k-1];
      assign w_gc    = r_c[k-1];
      assign w_vin   = r_v[k-1];
    end

    assign w_g = w_ain[k*BLOCK +: BLOCK] & w_bin[k*BLOCK +: BLOCK];
    assign w_p = w_ain[k*BLOCK +: BLOCK] ^ w_bin[k*BLOCK +: BLOCK];

    always_comb begin
      w_c[0] = w_gc;
      for (int i = 0; i < int'(BLOCK); i++) begin
        w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      end
    end

    always_comb begin
      w_snext                    = w_sbase;
      w_snext[k*BLOCK +: BLOCK]  = w_p ^ w_c[BLOCK-1:0];
    end

    // Operand copies beyond the consumed groups carry forward; only upper bits are ever read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
        r_ovf[k] <= 1'b0;
      end else if (w_adv) begin
        r_v[k]   <= w_vin;
        r_a[k]   <= w_ain;
        r_b[k]   <= w_bin;
        r_s[k]   <= w_snext;
        r_c[k]   <= w_c[BLOCK];
        r_ovf[k] <= w_c[BLOCK] ^ w_c[BLOCK-1];
      end
    end
  end

  assign out_valid = r_v[NSTAGE-1];
  assign s         = r_s[NSTAGE-1];
  assign cout      = r_c[NSTAGE-1];
  assign ovf       = r_ovf[NSTAGE-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three configurations (16/4, 32/8, 4/4) checked against an
// arithmetic reference model, plus directed vectors with literal expected results.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        cout_o    [3];
  logic        ovf_o     [3];
  logic [31:0] s_x       [3];
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        cin_in;
  logic        sub_in;
  logic [15:0] s0;
  logic [31:0] s1;
  logic [3:0]  s2;

  logic [33:0] exp_q [3][$];
  logic [33:0] held  [3];
  logic        hold  [3];
  int          n_out [3];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign s_x[0] = {16'b0, s0};
  assign s_x[1] = s1;
  assign s_x[2] = {28'b0, s2};

  cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .s(s0), .cout(cout_o[0]), .ovf(ovf_o[0])
  );

  cla_pipe_adder #(.WIDTH(32), .BLOCK(8)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .s(s1), .cout(cout_o[1]), .ovf(ovf_o[1])
  );

  cla_pipe_adder #(.WIDTH(4), .BLOCK(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .s(s2), .cout(cout_o[2]), .ovf(ovf_o[2])
  );

  function automatic int wd(input int d);
    case (d)
      0:       return 16;
      1:       return 32;
      default: return 4;
    endcase
  endfunction

  function automatic int lat(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  // Reference: plain modular arithmetic, {cout, ovf, s zero-extended to 32 bits}.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic sb);
    logic [31:0] mask;
    logic [31:0] bx;
    logic [32:0] sum;
    logic [31:0] r;
    logic        co;
    logic        ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    bx   = sb ? ~b : b;
    sum  = {1'b0, a & mask} + {1'b0, bx & mask} + {32'b0, (sb ? 1'b1 : c)};
    r    = sum[31:0] & mask;
    co   = sum[w];
    ov   = (a[w-1] == bx[w-1]) && (r[w-1] != a[w-1]);
    return {co, ov, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        exp_q[d].delete();
        hold[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        logic [33:0] got;
        logic [33:0] e;
        got = {cout_o[d], ovf_o[d], s_x[d]};
        if (hold[d]) chk($sformatf("hold_d%0d", d), {out_valid[d], got}, {1'b1, held[d]});
        if (in_valid[d] && in_ready[d])
          exp_q[d].push_back(model(wd(d), a_in, b_in, cin_in, sub_in));
        if (out_valid[d]) begin
          if (exp_q[d].size() == 0) begin
            chk($sformatf("unexpected_out_d%0d", d), {30'b0, got}, 64'h0);
          end else begin
            e = exp_q[d][0];
            chk($sformatf("result_d%0d", d), {30'b0, got}, {30'b0, e});
            if (out_ready[d]) begin
              void'(exp_q[d].pop_front());
              n_out[d]++;
            end
          end
        end
        hold[d] = out_valid[d] && !out_ready[d];
        held[d] = got;
      end
    end
  end

  task automatic directed(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic sb, input logic [33:0] exp);
    int   n;
    logic found;
    chk($sformatf("model_d%0d", d), {30'b0, model(wd(d), a, b, c, sb)}, {30'b0, exp});
    a_in = a; b_in = b; cin_in = c; sub_in = sb;
    in_valid[d] = 1'b1;
    n = 0;
    found = 1'b0;
    while (n < 20 && !found) begin
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      n++;
      if (out_valid[d]) found = 1'b1;
    end
    chk($sformatf("latency_d%0d", d), n, lat(d));
    chk($sformatf("directed_d%0d", d), {30'b0, cout_o[d], ovf_o[d], s_x[d]}, {30'b0, exp});
  endtask

  task automatic new_beat();
    a_in   = $urandom;
    b_in   = $urandom;
    cin_in = 1'($urandom_range(0, 1));
    sub_in = 1'($urandom_range(0, 1));
  endtask

  task automatic stream(input int d);
    int   sent;
    int   cyc;
    int   base;
    logic acc;
    sent = 0;
    cyc  = 0;
    base = n_out[d];
    new_beat();
    in_valid[d] = 1'b1;
    while (sent < 20 && cyc < 500) begin
      out_ready[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready[d];
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        new_beat();
      end
    end
    in_valid[d] = 1'b0;
    cyc = 0;
    while (n_out[d] - base < 20 && cyc < 500) begin
      out_ready[d] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    out_ready[d] = 1'b1;
    repeat (lat(d) + 3) @(posedge clk);
    #1;
    chk($sformatf("stream_count_d%0d", d), n_out[d] - base, 20);
    chk($sformatf("stream_drained_d%0d", d), exp_q[d].size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   base;
    logic seen;
    rst = 1'b1;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      n_out[d]     = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_state_d%0d", d),
          {out_valid[d], in_ready[d], cout_o[d], ovf_o[d], s_x[d]}, {4'b0100, 32'h0});
    rst = 1'b0;
    @(posedge clk); #1;

    directed(0, 32'h1234, 32'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 32'h5556});
    directed(0, 32'hFFFF, 32'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0000});
    directed(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000});
    directed(0, 32'h0005, 32'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFE});
    directed(1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0});
    directed(1, 32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    directed(2, 32'h7, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8});
    directed(2, 32'h3, 32'h5, 1'b0, 1'b1, {1'b0, 1'b0, 32'hE});

    for (int d = 0; d < 3; d++) stream(d);

    // Three beats in flight, then an asynchronous reset in the middle of a cycle.
    base = n_out[0];
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_beat();
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midreset_state", {out_valid[0], in_ready[0], cout_o[0], ovf_o[0], s_x[0]},
        {4'b0100, 32'h0});
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    chk("no_stale_beat", seen, 1'b0);
    chk("no_stale_count", n_out[0] - base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
